mux_1to1_32bit: RTL and testbench

//   Single-input 32-bit gated pass-through used on ALU operand/result paths.

---
 rtl/mux_1to1_32bit.sv | 56 +++++
 tb/tb_mux_1to1_32bit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mux_1to1_32bit.sv
// Gated pass-through: forwards a to y when sel is 1, otherwise drives zero.
// An optional output register (REG_OUT=1) adds one cycle of latency.
module mux_1to1_32bit #(
  parameter int WIDTH   = 32,
  parameter bit REG_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  logic             w_sel_hit;
  logic [WIDTH-1:0] w_gated;

  // NOTE: the explicit compare inside an if sends an X/Z sel to the else path,
  // so an unknown select gates the word to zero instead of propagating X.
  always_comb begin
    w_sel_hit = 1'b0;
    if (sel == 1'b1) begin
      w_sel_hit = 1'b1;
    end
  end

  assign w_gated = a & {WIDTH{w_sel_hit}};

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] r_y;
    logic             r_y_valid;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its inputs as they stood before the edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_y       <= '0;
        r_y_valid <= 1'b0;
      end else begin
        r_y       <= w_gated;
        r_y_valid <= w_sel_hit;
      end
    end

    assign y       = r_y;
    assign y_valid = r_y_valid;
  end else begin : g_comb
    // The clock has no function in this mode.
    logic w_unused_clk;
    assign w_unused_clk = clk;

    assign y       = w_gated & {WIDTH{~rst}};
    assign y_valid = w_sel_hit & ~rst;
  end

endmodule

// File: tb/tb_mux_1to1_32bit.sv
// Scoreboard bench for mux_1to1_32bit: a combinational and a registered
// instance are driven together and checked against a zero/forward model.
module tb_mux_1to1_32bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a   = '0;
  logic        sel = 1'b0;
  logic [31:0] y_c, y_r;
  logic        v_c, v_r;

  always #5 clk = ~clk;

  mux_1to1_32bit #(.WIDTH(32), .REG_OUT(1'b0)) u_comb (
    .clk(clk), .rst(rst), .a(a), .sel(sel), .y(y_c), .y_valid(v_c)
  );

  mux_1to1_32bit #(.WIDTH(32), .REG_OUT(1'b1)) u_reg (
    .clk(clk), .rst(rst), .a(a), .sel(sel), .y(y_r), .y_valid(v_r)
  );

  typedef struct {
    logic [31:0] y;
    logic        v;
  } exp_t;

  exp_t q_c[$];
  exp_t q_r[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: reset or any select other than a clean 1 gives zero, else a.
  function automatic exp_t model(input logic r, input logic [31:0] d, input logic s);
    exp_t e;
    e.v = (r == 1'b0) && (s === 1'b1);
    e.y = e.v ? d : 32'h0;
    return e;
  endfunction

  // Inputs change on the falling edge, halfway between capture edges.
  task automatic step(input logic r, input logic [31:0] d, input logic s);
    logic prev_r;
    @(negedge clk);
    prev_r = rst;
    rst    = r;
    a      = d;
    sel    = s;
    q_c.push_back(model(r, d, sel));
    q_r.push_back(model(r, d, sel));
    if (r || prev_r) begin
      #1;
      check("reg_y_in_reset_window", y_r, 32'h0);
      check("reg_valid_in_reset_window", {31'b0, v_r}, 32'h0);
    end
  endtask

  initial begin : comb_monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q_c.size() > 0) begin
        e = q_c.pop_front();
        check("comb_y", y_c, e.y);
        check("comb_valid", {31'b0, v_c}, {31'b0, e.v});
      end
    end
  end

  initial begin : reg_monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_r.size() > 0) begin
        e = q_r.pop_front();
        check("reg_y", y_r, e.y);
        check("reg_valid", {31'b0, v_r}, {31'b0, e.v});
      end
    end
  end

  initial begin : stimulus
    logic        r;
    logic [31:0] d;
    logic        s;
    int          waited;

    step(1'b1, 32'hFFFF_FFFF, 1'b1);
    step(1'b1, 32'h1234_5678, 1'b1);

    step(1'b0, 32'hFFFF_FFFF, 1'b1);
    step(1'b0, 32'h0000_0000, 1'b1);
    step(1'b0, 32'h0000_0001, 1'b1);

    step(1'b0, 32'hFFFF_FFFF, 1'b0);
    step(1'b0, 32'h0000_0000, 1'b0);
    step(1'b0, 32'h0000_0001, 1'b0);

    step(1'b0, 32'hA5A5_A5A5, 1'b1);
    step(1'b0, 32'hA5A5_A5A5, 1'b0);
    step(1'b0, 32'hA5A5_A5A5, 1'b1);
    step(1'b0, 32'h1234_5678, 1'b0);
    step(1'b0, 32'hCAFE_F00D, 1'b1);

    // Reset lands while a word is held in the output register.
    step(1'b0, 32'hDEAD_BEEF, 1'b1);
    step(1'b1, 32'hDEAD_BEEF, 1'b1);
    step(1'b0, 32'hDEAD_BEEF, 1'b1);
    step(1'b0, 32'hDEAD_BEEF, 1'b1);

    step(1'b0, 32'hFFFF_FFFF, 1'bx);

    for (int i = 0; i < 32; i++) begin
      step(1'b0, 32'h1 << i, 1'b1);
    end

    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 15) == 0);
      d = $urandom;
      s = 1'($urandom_range(0, 1));
      step(r, d, s);
    end

    waited = 0;
    while ((q_c.size() > 0 || q_r.size() > 0) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    #3;
    check("scoreboard_drained", 32'(q_c.size() + q_r.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
